serial_addsub_ctrl: RTL and testbench

//  Bit-serial add/subtract/set-less-than unit for the MIPS32 ALU area-optimised path.

---
 rtl/serial_addsub_ctrl.sv | 112 +++++++++++
 tb/tb_serial_addsub_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial add/sub/slt unit, one full-adder cell reused LSB first
module serial_addsub_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;

  logic             fa_sum, fa_cout, is_sub, ovf_full, lt;
  logic [WIDTH-1:0] sum_full, res_full;

  // The single shared full-adder cell
  assign fa_sum  = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_cout = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

  assign is_sub   = (op == 2'b01) || (op == 2'b10);
  assign sum_full = {fa_sum, acc};
  // carry flop holds the carry into the MSB while the last bit is processed
  assign ovf_full = carry ^ fa_cout;
  assign lt       = fa_sum ^ ovf_full;
  assign res_full = (op_q == 2'b10) ? {{(WIDTH-1){1'b0}}, lt} : sum_full;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      op_q     <= 2'b00;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= is_sub ? ~b : b;
            carry <= is_sub;
            cnt   <= '0;
            op_q  <= op;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          acc   <= sum_full[WIDTH-1:1];
          carry <= fa_cout;
          if (cnt == LAST) begin
            cnt      <= '0;
            result   <= res_full;
            cout     <= fa_cout;
            overflow <= ovf_full;
            zero     <= (res_full == '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - scoreboard bench for serial_addsub_ctrl (WIDTH=32)
module tb_serial_addsub_ctrl;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, overflow, zero;
  logic [W-1:0] result;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   prev_done_cyc = 0;
  int   last_done_cyc = 0;
  logic done_prev = 1'b0;
  exp_t sb[$];

  serial_addsub_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .cout(cout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
    exp_t e;
    logic [W:0] s;
    if (mop == 2'b01 || mop == 2'b10) begin
      s   = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
      e.v = (ma[W-1] != mb[W-1]) && (s[W-1] != ma[W-1]);
    end else begin
      s   = {1'b0, ma} + {1'b0, mb};
      e.v = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
    end
    e.c   = s[W];
    e.res = (mop == 2'b10) ? {{(W-1){1'b0}}, ($signed(ma) < $signed(mb))} : s[W-1:0];
    e.z   = (e.res == '0);
    return e;
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!rst && done) begin
      if (done_prev) check_val("done_pulse_width", 1, 0);
      if (sb.size() == 0) begin
        check_val("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("result", result, e.res);
        check_val("cout", cout, e.c);
        check_val("overflow", overflow, e.v);
        check_val("zero", zero, e.z);
      end
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
    done_prev = done;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_val("idle_timeout", 1, 0);
  endtask

  task automatic do_op(input logic [1:0] vop, input logic [W-1:0] va, input logic [W-1:0] vb, input int inject);
    int n;
    wait_idle();
    start = 1'b1; op = vop; a = va; b = vb;
    sb.push_back(model(vop, va, vb));
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    n = 1;
    while (!done && n < 100) begin
      if (inject > 0 && n == inject) begin
        start = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom);
      end
      if (inject > 0 && n == inject + 1) start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check_val("latency", n, W + 1);
  endtask

  vec_t vecs[$];

  initial begin
    int base, n;
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_result", result, 0);
    check_val("rst_flags", {cout, overflow, zero}, 0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{2'b00, 32'h0000_0005, 32'h0000_0003});
    vecs.push_back('{2'b00, 32'h7FFF_FFFF, 32'h0000_0001});
    vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'h0000_0001});
    vecs.push_back('{2'b01, 32'h0000_0005, 32'h0000_0005});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'h0000_0001});
    vecs.push_back('{2'b10, 32'hFFFF_FFFF, 32'h0000_0001});
    vecs.push_back('{2'b10, 32'h7FFF_FFFF, 32'h8000_0000});
    vecs.push_back('{2'b10, 32'h0000_0001, 32'hFFFF_FFFF});
    vecs.push_back('{2'b11, 32'h1234_5678, 32'h0F0F_0F0F});
    vecs.push_back('{2'b01, 32'h0000_0003, 32'h0000_0007});
    for (int i = 0; i < 6; i++) vecs.push_back('{2'($urandom), $urandom, $urandom});
    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0);

    // start pulsed with new operands while RUN
    do_op(2'b00, 32'h0000_1000, 32'h0000_0234, 3);

    // start held high: two back-to-back completions
    wait_idle();
    base = done_cnt;
    start = 1'b1; op = 2'b01; a = 32'h0000_0064; b = 32'h0000_0014;
    sb.push_back(model(2'b01, 32'h0000_0064, 32'h0000_0014));
    @(negedge clk);
    a = 32'h0000_0010; b = 32'h0000_0020;
    sb.push_back(model(2'b01, 32'h0000_0010, 32'h0000_0020));
    n = 0;
    while (done_cnt < base + 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done_cnt < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("held_count", done_cnt - base, 2);
    check_val("held_gap", last_done_cyc - prev_done_cyc, W + 2);

    // reset during RUN, after bit 10 is processed
    wait_idle();
    start = 1'b1; op = 2'b00; a = 32'h0000_00FF; b = 32'h0000_0001;
    sb.push_back(model(2'b00, 32'h0000_00FF, 32'h0000_0001));
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    check_val("midrst_result", result, 0);
    check_val("midrst_flags", {cout, overflow, zero}, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    base = done_cnt;
    repeat (3) @(negedge clk);
    check_val("midrst_no_done", done_cnt - base, 0);

    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    repeat (3) @(negedge clk);
    check_val("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
